// File: rtl/regfile_read_port_if.sv
// Bus bundle for regfile_read_port: write-back port, read request handshake
// and registered operand output handshake.
interface regfile_read_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_valid, rs_addr, rt_addr, out_ready,
        input  rd_ready, out_valid, rs_data, rt_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_valid, rs_addr, rt_addr, out_ready,
        output rd_ready, out_valid, rs_data, rt_data
    );
endinterface

// File: rtl/regfile_read_port.sv
// MIPS dual-read/single-write register file with a one-entry registered read stage.
// Define REGFILE_BYPASS_EN for write-before-read capture and held-operand refresh.
module regfile_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    regfile_read_port_if.slave  bus
);
    localparam int NREG = 1 << ADDR_W;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] regs [1:NREG-1];
    logic              out_valid_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [ADDR_W-1:0] rs_q;
    logic [ADDR_W-1:0] rt_q;
    logic [DATA_W-1:0] rs_lookup;
    logic [DATA_W-1:0] rt_lookup;
    logic              rd_ready;
    logic              accept;
    logic              wr_hit;

    assign rd_ready      = !out_valid_q || bus.out_ready;
    assign accept        = bus.rd_valid && rd_ready;
    assign wr_hit        = bus.wr_en && (bus.wr_addr != '0);

    assign bus.rd_ready  = rd_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.rs_data   = rs_data_q;
    assign bus.rt_data   = rt_data_q;

    // Index 0 has no storage; writes to it fall through untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        rs_lookup = '0;
        rt_lookup = '0;
        if (bus.rs_addr != '0) begin
            rs_lookup = regs[bus.rs_addr];
        end
        if (bus.rt_addr != '0) begin
            rt_lookup = regs[bus.rt_addr];
        end
        if (BYPASS && wr_hit) begin
            if (bus.wr_addr == bus.rs_addr) begin
                rs_lookup = bus.wr_data;
            end
            if (bus.wr_addr == bus.rt_addr) begin
                rt_lookup = bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            rs_data_q   <= rs_lookup;
            rt_data_q   <= rt_lookup;
            rs_q        <= bus.rs_addr;
            rt_q        <= bus.rt_addr;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end else if (BYPASS && out_valid_q && wr_hit) begin
            // Stalled operands track write-back so the consumer never sees stale data.
            if (bus.wr_addr == rs_q) begin
                rs_data_q <= bus.wr_data;
            end
            if (bus.wr_addr == rt_q) begin
                rt_data_q <= bus.wr_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_read_port.sv
// Directed scoreboard bench for regfile_read_port; expectations follow
// REGFILE_BYPASS_EN when it is defined.
module tb_regfile_read_port;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic [63:0] exp_q [$];

    regfile_read_port_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_read_port #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got rs=%h rt=%h expected no output", bus.rs_data, bus.rt_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("rs_data", bus.rs_data, e[63:32]);
                check("rt_data", bus.rt_data, e[31:0]);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic read_req(input logic [4:0] rs, input logic [4:0] rt,
                            input logic [31:0] ers, input logic [31:0] ert, input bit push);
        int waitc;
        waitc = 0;
        bus.rd_valid = 1'b1;
        bus.rs_addr = rs;
        bus.rt_addr = rt;
        forever begin
            @(negedge clk);
            if (bus.rd_ready === 1'b1) break;
            waitc++;
            if (waitc > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got rd_ready=%b expected 1", bus.rd_ready);
                bus.rd_valid = 1'b0;
                return;
            end
        end
        if (push) exp_q.push_back({ers, ert});
        @(posedge clk);
        #1;
        bus.rd_valid = 1'b0;
    endtask

    initial begin
        int c0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_valid = 1'b0;
        bus.rs_addr = '0;
        bus.rt_addr = '0;
        bus.out_ready = 1'b1;

        #12;
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_rd_ready", {31'b0, bus.rd_ready}, 32'd1);
        check("reset_rs_data", bus.rs_data, 32'd0);
        check("reset_rt_data", bus.rt_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        read_req(5'd0, 5'd31, 32'd0, 32'd0, 1'b1);
        check("first_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("first_rd_ready", {31'b0, bus.rd_ready}, 32'd1);
        idle(2);

        write_reg(5'd5, 32'hDEADBEEF);
        write_reg(5'd0, 32'h12345678);
        read_req(5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 1'b1);
        read_req(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);

        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFFFFFF;
        read_req(5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
        bus.wr_en = 1'b0;

        write_reg(5'd7, 32'h00000001);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'hA5A5A5A5;
        read_req(5'd7, 5'd0, BYP ? 32'hA5A5A5A5 : 32'h00000001, 32'd0, 1'b1);
        bus.wr_en = 1'b0;
        read_req(5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1);

        write_reg(5'd1, 32'h11);
        write_reg(5'd2, 32'h22);
        write_reg(5'd3, 32'h33);
        write_reg(5'd4, 32'h44);
        idle(2);
        c0 = cyc;
        read_req(5'd1, 5'd4, 32'h11, 32'h44, 1'b1);
        read_req(5'd2, 5'd3, 32'h22, 32'h33, 1'b1);
        read_req(5'd3, 5'd2, 32'h33, 32'h22, 1'b1);
        read_req(5'd4, 5'd1, 32'h44, 32'h11, 1'b1);
        check("b2b_cycles", cyc - c0, 32'd4);
        idle(3);

        // Stall with a held read of $9, then a competing request and a write to $9.
        write_reg(5'd9, 32'h99);
        idle(1);
        bus.out_ready = 1'b0;
        read_req(5'd0, 5'd9, 32'd0, BYP ? 32'h55 : 32'h99, 1'b1);
        bus.rd_valid = 1'b1; bus.rs_addr = 5'd1; bus.rt_addr = 5'd2;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h55;
        @(negedge clk);
        check("stall_rd_ready", {31'b0, bus.rd_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("stall_rt_data", bus.rt_data, BYP ? 32'h55 : 32'h99);
        check("stall_rd_ready2", {31'b0, bus.rd_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.rd_valid = 1'b0;
        bus.out_ready = 1'b1;
        idle(1);
        check("drain_out_valid", {31'b0, bus.out_valid}, 32'd0);
        read_req(5'd9, 5'd0, 32'h55, 32'd0, 1'b1);
        idle(2);

        // Asynchronous reset while an operand pair is stalled.
        write_reg(5'd3, 32'h77);
        bus.out_ready = 1'b0;
        read_req(5'd3, 5'd3, 32'h77, 32'h77, 1'b0);
        check("pre_reset_rs", bus.rs_data, 32'h77);
        check("pre_reset_valid", {31'b0, bus.out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async_rs_data", bus.rs_data, 32'd0);
        check("async_rt_data", bus.rt_data, 32'd0);
        check("async_rd_ready", {31'b0, bus.rd_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        read_req(5'd3, 5'd5, 32'd0, 32'd0, 1'b1);
        idle(4);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end
endmodule
